// File: rtl/disp_colour_adapt.sv
// rtl/disp_colour_adapt.sv - 2-stage colour-depth adapter; optional dither via DISP_COLOUR_ADAPT_DITHER_EN
module disp_colour_adapt #(
   parameter int BPC_IN   = 5,
   parameter int BPC_OUT  = 8,
   parameter int CHANNELS = 3
) (
   input  logic                         clk_pix,
   input  logic                         rst_pix,
   input  logic                         frame_in,
   input  logic                         de_in,
   input  logic                         hsync_in,
   input  logic                         vsync_in,
   input  logic [CHANNELS*BPC_IN-1:0]   din,
   output logic                         de_out,
   output logic                         hsync_out,
   output logic                         vsync_out,
   output logic [CHANNELS*BPC_OUT-1:0]  dout
);

   localparam int WI = CHANNELS * BPC_IN;
   localparam int WO = CHANNELS * BPC_OUT;

   logic [WI-1:0] din_q;
   logic          de_q, hs_q, vs_q;
   logic [WO-1:0] conv;
   logic [WO-1:0] dout_d, dout_q;
   logic          de2_q, hs2_q, vs2_q;

   // frame_in only drives the dither position logic; keep it referenced otherwise
   logic unused_frame;
   assign unused_frame = frame_in;

   // Stage 1: capture colour and timing inputs
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         din_q <= '0;
         de_q  <= 1'b0;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         din_q <= din;
         de_q  <= de_in;
         hs_q  <= hsync_in;
         vs_q  <= vsync_in;
      end
   end

   generate
      if (BPC_IN > BPC_OUT) begin : g_narrow
         localparam int D = BPC_IN - BPC_OUT;
         logic [BPC_IN:0] off_d, off_q;

`ifdef DISP_COLOUR_ADAPT_DITHER_EN
         logic       xpar_q, ypar_q, fpar_q, de_prev_q;
         logic [1:0] bayer;

         // 2x2 ordered-dither threshold M = {{0,2},{3,1}}, column flipped on odd frames
         always_comb begin
            bayer = 2'd0;
            case ({ypar_q, xpar_q ^ fpar_q})
               2'b00:   bayer = 2'd0;
               2'b01:   bayer = 2'd2;
               2'b10:   bayer = 2'd3;
               default: bayer = 2'd1;
            endcase
         end

         assign off_d = ({{(BPC_IN-1){1'b0}}, bayer} << D) >> 2;

         // Pixel/line/frame parity tracking; frame start overrides a coincident line end
         always_ff @(posedge clk_pix or posedge rst_pix) begin
            if (rst_pix) begin
               xpar_q    <= 1'b0;
               ypar_q    <= 1'b0;
               fpar_q    <= 1'b0;
               de_prev_q <= 1'b0;
            end else begin
               de_prev_q <= de_in;
               if (de_in)
                  xpar_q <= ~xpar_q;
               else if (de_prev_q)
                  xpar_q <= 1'b0;
               if (frame_in) begin
                  ypar_q <= 1'b0;
                  fpar_q <= ~fpar_q;
               end else if (!de_in && de_prev_q) begin
                  ypar_q <= ~ypar_q;
               end
            end
         end
`else
         assign off_d = {{BPC_IN{1'b0}}, 1'b1} << (D - 1);
`endif

         // Offset travels with the pixel through stage 1
         always_ff @(posedge clk_pix or posedge rst_pix) begin
            if (rst_pix)
               off_q <= '0;
            else
               off_q <= off_d;
         end

         for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            logic [BPC_IN:0] sum;
            assign sum = {1'b0, din_q[ch*BPC_IN +: BPC_IN]} + off_q;
            assign conv[ch*BPC_OUT +: BPC_OUT] = sum[BPC_IN] ? {BPC_OUT{1'b1}} : sum[BPC_IN-1:D];
         end
      end else if (BPC_OUT > BPC_IN) begin : g_widen
         // Output bits walk the input from MSB down, wrapping until filled
         for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
            for (genvar k = 0; k < BPC_OUT; k++) begin : g_bit
               assign conv[ch*BPC_OUT + BPC_OUT-1-k] = din_q[ch*BPC_IN + BPC_IN-1-(k % BPC_IN)];
            end
         end
      end else begin : g_equal
         assign conv = din_q;
      end
   endgenerate

   assign dout_d = de_q ? conv : '0;

   // Stage 2: register converted colour (blanked outside de) and delayed timing
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         dout_q <= '0;
         de2_q  <= 1'b0;
         hs2_q  <= 1'b0;
         vs2_q  <= 1'b0;
      end else begin
         dout_q <= dout_d;
         de2_q  <= de_q;
         hs2_q  <= hs_q;
         vs2_q  <= vs_q;
      end
   end

   assign dout      = dout_q;
   assign de_out    = de2_q;
   assign hsync_out = hs2_q;
   assign vsync_out = vs2_q;

endmodule

// File: tb/tb_disp_colour_adapt.sv
// tb/tb_disp_colour_adapt.sv - directed bench for disp_colour_adapt (5->8 and 8->5 instances)
module tb_disp_colour_adapt;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_in = 1'b0;
   logic        de_in = 1'b0;
   logic        hs_in = 1'b0;
   logic        vs_in = 1'b0;
   logic [23:0] din_n = '0;
   logic [14:0] din_w = '0;
   logic [14:0] dout_n;
   logic [23:0] dout_w;
   logic        de_n, hs_n, vs_n, de_w, hs_w, vs_w;

   int n_tests = 0;
   int n_fail  = 0;

   logic        p_valid = 1'b0;
   logic [14:0] p_en = '0;
   logic [23:0] p_ew = '0;
   logic [2:0]  p_ctl = '0;

`ifdef DISP_COLOUR_ADAPT_DITHER_EN
   localparam logic [14:0] DQ1 = 15'h0421;
`else
   localparam logic [14:0] DQ1 = 15'h0000;
`endif

   disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .CHANNELS(3)) u_narrow (
      .clk_pix(clk), .rst_pix(rst), .frame_in(frame_in), .de_in(de_in),
      .hsync_in(hs_in), .vsync_in(vs_in), .din(din_n),
      .de_out(de_n), .hsync_out(hs_n), .vsync_out(vs_n), .dout(dout_n));

   disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .CHANNELS(3)) u_wide (
      .clk_pix(clk), .rst_pix(rst), .frame_in(frame_in), .de_in(de_in),
      .hsync_in(hs_in), .vsync_in(vs_in), .din(din_w),
      .de_out(de_w), .hsync_out(hs_w), .vsync_out(vs_w), .dout(dout_w));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [14:0] en, input logic [23:0] ew,
                            input logic [2:0] ctl);
      check({tag, ".dout_n"}, {17'd0, dout_n}, {17'd0, en});
      check({tag, ".dout_w"}, {8'd0, dout_w}, {8'd0, ew});
      check({tag, ".ctl_n"}, {29'd0, de_n, hs_n, vs_n}, {29'd0, ctl});
      check({tag, ".ctl_w"}, {29'd0, de_w, hs_w, vs_w}, {29'd0, ctl});
   endtask

   // Apply one cycle of inputs; after the edge, outputs belong to the previous step
   task automatic step(input string tag, input logic de, input logic fr, input logic hs,
                       input logic vs, input logic [23:0] dn, input logic [14:0] dw,
                       input logic [14:0] en, input logic [23:0] ew);
      de_in = de; frame_in = fr; hs_in = hs; vs_in = vs; din_n = dn; din_w = dw;
      @(posedge clk); #1;
      if (p_valid) check_all(tag, p_en, p_ew, p_ctl);
      p_valid = 1'b1;
      p_en  = de ? en : 15'd0;
      p_ew  = de ? ew : 24'd0;
      p_ctl = {de, hs, vs};
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 15'd0, 24'd0, 3'b000);
      rst = 1'b0;

      // widening 5->8 and narrowing 8->5 rounding/saturation
      step("idle",  1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 15'd0, 15'd0, 24'd0);
      step("w1",    1'b1, 1'b0, 1'b0, 1'b0, 24'h0304FF, 15'h7FFF, 15'h003F, 24'hFFFFFF);
      step("w2",    1'b1, 1'b0, 1'b0, 1'b1, 24'h807BFC, 15'h4210, 15'h41FF, 24'h848484);
      step("w3",    1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 15'h02A1, 15'h0000, 24'h00AD08);
      // blanking with sync passthrough
      step("blank", 1'b0, 1'b0, 1'b1, 1'b0, 24'hFFFFFF, 15'h7FFF, 15'd0, 24'd0);
      step("line",  1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 15'h0001, 15'h0000, 24'h000008);
      step("flush", 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 15'h0000, 15'h0000, 24'h000000);

      // asynchronous reset mid-line
      rst = 1'b1;
      #1;
      check_all("rst_async", 15'd0, 24'd0, 3'b000);
      p_valid = 1'b0;
      de_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      p_valid = 1'b1; p_en = '0; p_ew = '0; p_ctl = '0;

      // 2x2 block from restarted parities (fpar=0)
      step("f0x0y0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'h7FFF, 15'h0000, 24'hFFFFFF);
      step("f0x1y0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("f0eol0", 1'b0, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'd0, 24'd0);
      step("f0x0y1", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, DQ1, 24'd0);
      step("f0x1y1", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("f0eol1", 1'b0, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'd0, 24'd0);
      step("frame1", 1'b0, 1'b1, 1'b0, 1'b1, 24'h020202, 15'd0, 15'd0, 24'd0);
      // next frame (fpar=1)
      step("f1x0y0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("f1x1y0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("f1eol0", 1'b0, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'd0, 24'd0);
      step("f1x0y1", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("f1x1y1", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, DQ1, 24'd0);
      // frame start coincident with line end: next line must use ypar=0 (fpar back to 0)
      step("fr_eol", 1'b0, 1'b1, 1'b0, 1'b0, 24'h020202, 15'd0, 15'd0, 24'd0);
      step("f2x0y0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("f2x1y0", 1'b1, 1'b0, 1'b0, 1'b0, 24'h020202, 15'd0, 15'h0000, 24'd0);
      step("end",    1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 15'd0, 15'd0, 24'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
